// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-serial RAM port arbiter for instruction fetch and MEM stage (optional MEM_ARB_RR_EN: round-robin grant)
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    input  logic              flush,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

    state_t            state, state_nx;
    logic [2:0]        k;        // address index; also counts cycles within the transfer
    logic [2:0]        cap;      // index of the next byte to capture from ram_din
    logic [2:0]        n_bytes;
    logic [2:0]        k_inc;
    logic [DATA_W-1:0] rbuf;     // partial read word, kept apart so outputs hold until completion
    logic [DATA_W-1:0] wbuf;
    logic [DATA_W-1:0] rd_word;
    logic              req_if_ok, req_mem_ok;
    logic              grant_if, grant_mem;
    logic              rd_active;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

`ifdef MEM_ARB_RR_EN
    logic last_mem;

    // Remember which requester was served last so a tie goes to the other one
    always_ff @(posedge clk) begin
        if (rst)
            last_mem <= 1'b0;
        else if (grant_if || grant_mem)
            last_mem <= grant_mem;
    end
`endif

    // Arbitration, next-state selection and read-word assembly
    always_comb begin
        req_mem_ok = mem_req && !if_done && !mem_done;
        req_if_ok  = if_req && !flush && !if_done && !mem_done;
        grant_mem  = 1'b0;
        grant_if   = 1'b0;
        k_inc      = k + 3'd1;
        rd_active  = (state == IF_RD && !flush) || state == MEM_RD;
        rd_word    = rbuf;
        rd_word[{cap[1:0], 3'b000} +: 8] = ram_din;
        if (state == IDLE) begin
`ifdef MEM_ARB_RR_EN
            grant_mem = req_mem_ok && (!req_if_ok || !last_mem);
`else
            grant_mem = req_mem_ok;
`endif
            grant_if  = req_if_ok && !grant_mem;
        end
        state_nx = state;
        case (state)
            IDLE: begin
                if (grant_mem)
                    state_nx = mem_we ? MEM_WR : MEM_RD;
                else if (grant_if)
                    state_nx = IF_RD;
            end
            IF_RD: begin
                if (flush || k == n_bytes + 3'd1)
                    state_nx = IDLE;
            end
            MEM_RD: begin
                if (k == n_bytes + 3'd1)
                    state_nx = IDLE;
            end
            MEM_WR: begin
                if (k == n_bytes)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Address sequencing, byte capture/emission and done pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            k         <= '0;
            cap       <= '0;
            n_bytes   <= '0;
            rbuf      <= '0;
            wbuf      <= '0;
            ram_a     <= '0;
            ram_wr    <= 1'b0;
            ram_dout  <= '0;
            if_data   <= '0;
            mem_rdata <= '0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_mem || grant_if) begin
                        k       <= '0;
                        cap     <= '0;
                        rbuf    <= '0;
                        ram_a   <= grant_mem ? mem_addr : if_addr;
                        n_bytes <= grant_mem ? len_bytes(mem_len) : 3'd4;
                    end
                    if (grant_mem && mem_we) begin
                        ram_wr   <= 1'b1;
                        ram_dout <= mem_wdata[7:0];
                        wbuf     <= mem_wdata;
                    end
                end
                IF_RD, MEM_RD: begin
                    if (rd_active) begin
                        k <= k_inc;
                        if (k_inc < n_bytes)
                            ram_a <= ram_a + ADDR_W'(1);
                        // ram_din lags its address by one cycle, so capture starts at k = 1
                        if (k != 3'd0 && cap < n_bytes) begin
                            cap <= cap + 3'd1;
                            if (cap == n_bytes - 3'd1) begin
                                if (state == IF_RD) begin
                                    if_data <= rd_word;
                                    if_done <= 1'b1;
                                end else begin
                                    mem_rdata <= rd_word;
                                    mem_done  <= 1'b1;
                                end
                            end else begin
                                rbuf <= rd_word;
                            end
                        end
                    end
                end
                MEM_WR: begin
                    k <= k_inc;
                    if (k_inc < n_bytes) begin
                        ram_a    <= ram_a + ADDR_W'(1);
                        ram_dout <= wbuf[{k_inc[1:0], 3'b000} +: 8];
                    end else if (k_inc == n_bytes) begin
                        ram_wr   <= 1'b0;
                        mem_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-wide RAM port between instruction fetch (IF) and the MEM stage.
- Accepts word-fetch and load/store requests and sequences them into byte-serial little-endian RAM accesses.
- Returns assembled data with one-cycle done pulses.
- Aborts an in-flight fetch when a jump redirects the PC.

Parameters:
- ADDR_W, 32, RAM address width.
- DATA_W, 32, requester data width; fixed at 4 bytes.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- if_req  in  1  fetch request; held until if_done
- if_addr  in  ADDR_W  fetch byte address
- if_done  out  1  one-cycle pulse; if_data valid
- if_data  out  DATA_W  fetched word
- mem_req  in  1  load/store request; held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_len  in  2  0 = 1 byte, 1 = 2 bytes, 2 or 3 = 4 bytes
- mem_addr  in  ADDR_W  data byte address
- mem_wdata  in  DATA_W  store data; low bytes used
- mem_done  out  1  one-cycle pulse; mem_rdata valid
- mem_rdata  out  DATA_W  load data, zero-extended
- flush  in  1  jump taken; aborts IF traffic
- ram_a  out  ADDR_W  RAM address
- ram_wr  out  1  RAM write strobe
- ram_dout  out  8  RAM write byte
- ram_din  in  8  RAM read byte; valid the cycle after its address
- busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs are zero and the state is IDLE, including ram_a, ram_wr, ram_dout, if_data, mem_rdata, the done pulses and busy. Reset mid-transaction abandons the transaction and emits no done.
- States:
  - IDLE
  - IF_RD: 4-byte read
  - MEM_RD: n-byte read
  - MEM_WR: n-byte write
- Counters: 3-bit address counter k and 3-bit capture counter.
- Accept in IDLE only. No request is accepted in a cycle where if_done or mem_done is high, because requesters drop req the cycle after done.
- Arbitration: if both requests are pending, MEM wins. IF is not accepted at an edge where flush = 1.
- Read of n bytes, accepted at edge E0:
  - ram_a = base + k during cycles 1..n.
  - Byte k is captured from ram_din at the end of cycle k+2 into bits [8k+7:8k].
  - Done is high in cycle n+2 with data stable; the state returns to IDLE at the same edge.
  - Unused upper bytes are 0.
- Write of n bytes:
  - In cycles 1..n, ram_wr = 1, ram_a = base + k, ram_dout = mem_wdata[8k+7:8k].
  - mem_done is high in cycle n+1.
  - ram_wr = 0 in every other cycle.
- Address arithmetic is base + k mod 2^ADDR_W, so addresses wrap past all-ones to 0.
- ram_a holds its last value while IDLE.
- Flush:
  - Sampled high at an edge in IF_RD: go to IDLE, no if_done, if_data unchanged.
  - A pending MEM request may be accepted at the next IDLE edge.
  - Flush never affects MEM_RD or MEM_WR.
- if_data and mem_rdata hold their value until the next completion of the same requester.
- busy = 1 in every non-IDLE state.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. A last-grant bit (reset to IF) gives the next simultaneous-request grant to the requester not served last. A single requester is always granted.
- Undefined: fixed MEM-over-IF priority as described in Behaviour. The last-grant bit does not exist.

Test Plan:
- if_req, if_addr = 0x100, RAM bytes 0x13,0x05,0x10,0x00 at 0x100..0x103 -> ram_a = 0x100..0x103 in cycles 1..4; if_done in cycle 6 with if_data = 0x00100513.
- mem_req store, mem_len = 1, mem_addr = 0x2000, mem_wdata = 0xAABBCCDD -> ram_wr with 0xDD@0x2000 and 0xCC@0x2001; mem_done in cycle 3; RAM 0x2002 untouched.
- if_req and mem_req (1-byte load @0x40 = 0x8F) in the same cycle -> mem_done first with mem_rdata = 0x0000008F; IF accepted after; if_done follows. With MEM_ARB_RR_EN after a prior MEM grant -> IF is served first.
- IF read in progress, flush pulsed in cycle 3 -> no if_done; busy = 0 next cycle; a subsequent if_addr = 0x200 fetch completes normally.
- 4-byte load at 0xFFFFFFFE -> ram_a sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- rst asserted during a MEM_WR second byte -> ram_wr = 0, busy = 0 next cycle, no mem_done, remaining bytes unwritten.
